// File: rtl/isu_ctrl_pkg.sv
// Shared definitions for the issue controller: register-id width, in-flight cap and FSM states.
package isu_ctrl_pkg;

  localparam int unsigned REG_ADDRW        = 5;
  localparam int unsigned ISU_MAX_INFLIGHT = 4;
  localparam int unsigned ISU_ST_WIDTH     = 2;

  typedef enum logic [ISU_ST_WIDTH-1:0] {
    ISU_S_RUN       = 2'd0,
    ISU_S_CTRL_WAIT = 2'd1,
    ISU_S_HALT      = 2'd2
  } isu_state_e;

endpackage

// File: rtl/isu_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module isu_scoreboard
  import isu_ctrl_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_set_en,
  input  logic [REG_ADDRW-1:0] i_set_idx,
  input  logic                 i_clr_en,
  input  logic [REG_ADDRW-1:0] i_clr_idx,
  input  logic [REG_ADDRW-1:0] i_rs1_idx,
  input  logic [REG_ADDRW-1:0] i_rs2_idx,
  input  logic [REG_ADDRW-1:0] i_rd_idx,
  output logic                 o_rs1_pend,
  output logic                 o_rs2_pend,
  output logic                 o_rd_pend
);

  localparam int unsigned NREGS = 2 ** REG_ADDRW;

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  // Clear is applied before set so a same-index collision leaves the bit set.
  always_comb begin
    pend_d = pend_q;
    if (i_clr_en) pend_d[i_clr_idx] = 1'b0;
    if (i_set_en) pend_d[i_set_idx] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) pend_q <= '0;
    else          pend_q <= pend_d;
  end

  assign o_rs1_pend = (i_rs1_idx != '0) & pend_q[i_rs1_idx];
  assign o_rs2_pend = (i_rs2_idx != '0) & pend_q[i_rs2_idx];
  assign o_rd_pend  = (i_rd_idx  != '0) & pend_q[i_rd_idx];

endmodule

// File: rtl/isu_ctrl.sv
// Issue controller: gates the idu->exu handshake on data, structural, control and occupancy hazards.
module isu_ctrl
  import isu_ctrl_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = ISU_MAX_INFLIGHT,
  parameter int unsigned CNTW         = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic [REG_ADDRW-1:0] i_rs1id,
  input  logic [REG_ADDRW-1:0] i_rs2id,
  input  logic [REG_ADDRW-1:0] i_rdid,
  input  logic                 i_rdwen,
  input  logic                 i_muldiv,
  input  logic                 i_ctrl,
  input  logic                 i_fence,
  input  logic                 i_halt,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  input  logic                 i_retire,
  input  logic                 i_retire_rdwen,
  input  logic [REG_ADDRW-1:0] i_retire_rdid,
  input  logic                 i_md_done,
  input  logic                 i_ctrl_done,
  output logic                 o_stall,
  output logic [CNTW-1:0]      o_inflight,
  output logic                 o_halted
);

  isu_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            md_busy_q, md_busy_d;

  logic rs1_pend, rs2_pend, rd_pend;
  logic can_issue;
  logic fire;
  logic dec;

  isu_scoreboard u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_set_en   (fire & i_rdwen),
    .i_set_idx  (i_rdid),
    .i_clr_en   (i_retire & i_retire_rdwen),
    .i_clr_idx  (i_retire_rdid),
    .i_rs1_idx  (i_rs1id),
    .i_rs2_idx  (i_rs2id),
    .i_rd_idx   (i_rdid),
    .o_rs1_pend (rs1_pend),
    .o_rs2_pend (rs2_pend),
    .o_rd_pend  (rd_pend)
  );

  // Hazard checks see only registered tracking state; no same-cycle retire bypass.
  always_comb begin
    can_issue = (state_q == ISU_S_RUN)
              & ~rs1_pend & ~rs2_pend
              & ~(i_rdwen & rd_pend)
              & ~(i_muldiv & md_busy_q)
              & (cnt_q < CNTW'(MAX_INFLIGHT))
              & ~(i_fence & (cnt_q != '0));
  end

  assign o_post_valid = i_rst_n & i_pre_valid & can_issue;
  assign o_pre_ready  = i_rst_n & can_issue & i_post_ready;
  assign o_stall      = i_rst_n & i_pre_valid & ~can_issue;
  assign fire         = o_post_valid & i_post_ready;

  // A retire with nothing in flight is dropped.
  assign dec = i_retire & (cnt_q != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_busy_d = md_busy_q;

    unique case (state_q)
      ISU_S_RUN: begin
        if (fire && i_halt)      state_d = ISU_S_HALT;
        else if (fire && i_ctrl) state_d = ISU_S_CTRL_WAIT;
      end
      ISU_S_CTRL_WAIT: begin
        if (i_ctrl_done) state_d = ISU_S_RUN;
      end
      ISU_S_HALT: state_d = ISU_S_HALT;
      default:    state_d = ISU_S_RUN;
    endcase

    if (fire && !dec)      cnt_d = cnt_q + CNTW'(1);
    else if (!fire && dec) cnt_d = cnt_q - CNTW'(1);

    if (fire && i_muldiv) md_busy_d = 1'b1;
    else if (i_md_done)   md_busy_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ISU_S_RUN;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
    end
  end

  assign o_inflight = cnt_q;
  assign o_halted   = (state_q == ISU_S_HALT);

endmodule
